// File: rtl/types_def.sv
// Shared type definitions for the request path: the request type
// enumeration, the bank-queue entry record and bank-array sizing.
package types_def;

  // Request type carried with every request: read = 0, write = 1.
  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type;

  localparam int unsigned BANK_Q_DEPTH = 8;
  localparam int unsigned BANK_COUNT   = 16;
  localparam int unsigned BANK_INDEX_W = 6;
  localparam int unsigned BANK_ROW_W   = 16;

  typedef struct packed {
    r_type                   req_type;
    logic [BANK_INDEX_W-1:0] index;
    logic [BANK_ROW_W-1:0]   row;
  } bank_entry;

endpackage

// File: rtl/bank_queue_if.sv
// Push/pop handshake bundle of one bank queue.
//   in_valid/in_index/in_type/in_row : push from the address mapper
//   busy                             : queue full back to the mapper
//   out_valid/out_ready              : handshake with the bank scheduler
//   out_index/out_type/out_row       : selected entry
// master = mapper/scheduler side, slave = queue side.
interface bank_queue_if
  import types_def::*;
#(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned ROW_W   = 16
) ();

  logic               in_valid;
  logic [INDEX_W-1:0] in_index;
  r_type              in_type;
  logic [ROW_W-1:0]   in_row;
  logic               busy;

  logic               out_valid;
  logic               out_ready;
  logic [INDEX_W-1:0] out_index;
  r_type              out_type;
  logic [ROW_W-1:0]   out_row;

  modport master (
    output in_valid, in_index, in_type, in_row, out_ready,
    input  busy, out_valid, out_index, out_type, out_row
  );

  modport slave (
    input  in_valid, in_index, in_type, in_row, out_ready,
    output busy, out_valid, out_index, out_type, out_row
  );

endinterface

// File: rtl/bank_queue_array.sv
// Sixteen bank queues behind the address mapper. Each bank sees its own bit
// of bank_out_valid plus the shared {index, type, row} bus; the per-bank
// busy bits are gathered into in_busy for the mapper.
//   bank_out_valid : per-bank push strobes
//   in_index/in_type/in_row : shared request bus
//   out_ready/out_valid/out_entry : per-bank scheduler handshake
//   in_busy        : per-bank full flags back to the mapper
//   count/err_overflow : per-bank occupancy and sticky overflow
module bank_queue_array
  import types_def::*;
(
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [BANK_COUNT-1:0]                            bank_out_valid,
  input  logic [BANK_INDEX_W-1:0]                          in_index,
  input  r_type                                            in_type,
  input  logic [BANK_ROW_W-1:0]                            in_row,
  input  logic [BANK_COUNT-1:0]                            out_ready,
  output logic [BANK_COUNT-1:0]                            out_valid,
  output bank_entry [BANK_COUNT-1:0]                       out_entry,
  output logic [BANK_COUNT-1:0]                            in_busy,
  output logic [BANK_COUNT-1:0][$clog2(BANK_Q_DEPTH):0]    count,
  output logic [BANK_COUNT-1:0]                            err_overflow
);

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    bank_queue_if #(
      .INDEX_W (BANK_INDEX_W),
      .ROW_W   (BANK_ROW_W)
    ) bq ();

    assign bq.in_valid  = bank_out_valid[b];
    assign bq.in_index  = in_index;
    assign bq.in_type   = in_type;
    assign bq.in_row    = in_row;
    assign bq.out_ready = out_ready[b];

    assign in_busy[b]   = bq.busy;
    assign out_valid[b] = bq.out_valid;
    assign out_entry[b] = '{req_type: bq.out_type, index: bq.out_index, row: bq.out_row};

    bank_queue #(
      .DEPTH    (BANK_Q_DEPTH),
      .INDEX_W  (BANK_INDEX_W),
      .ROW_W    (BANK_ROW_W),
      .MAX_HITS (4)
    ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .bq           (bq.slave),
      .count        (count[b]),
      .err_overflow (err_overflow[b])
    );
  end

endmodule

// File: rtl/bank_queue_select.sv
// Row-hit selector for the bank queue: returns the lowest live slot whose
// row matches the open row, plus a hit flag. Purely combinational.
//   rows_i       : row of every slot
//   live_i       : slot holds a valid entry
//   open_row_i   : currently open row
//   open_valid_i : open_row_i is meaningful
//   slot_o       : lowest matching slot (0 when no hit)
//   hit_o        : a matching slot was found
module bank_queue_select
  import types_def::*;
#(
  parameter int unsigned DEPTH = BANK_Q_DEPTH,
  parameter int unsigned ROW_W = BANK_ROW_W
) (
  input  logic [DEPTH-1:0][ROW_W-1:0] rows_i,
  input  logic [DEPTH-1:0]            live_i,
  input  logic [ROW_W-1:0]            open_row_i,
  input  logic                        open_valid_i,
  output logic [$clog2(DEPTH)-1:0]    slot_o,
  output logic                        hit_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic                 found;
  logic [AW-1:0]        slot;

  always_comb begin
    found = 1'b0;
    slot  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && open_valid_i && live_i[i] && (rows_i[i] == open_row_i)) begin
        found = 1'b1;
        slot  = AW'(i);
      end
    end
  end

  assign slot_o = slot;
  assign hit_o  = found;

endmodule

// File: rtl/bank_queue.sv
// Per-bank request queue. Compacting array: slot 0 is the oldest entry,
// live entries occupy slots 0..count-1. A pop removes the selected slot and
// shifts younger entries down; a push lands at the first free slot after
// that compaction. busy is decoded from the registered count.
//   clk, rst     : clock, synchronous active-high reset
//   bq (slave)   : push/pop handshake bundle
//   count        : current occupancy
//   err_overflow : sticky, push attempted while full
// Optional feature macro BANK_QUEUE_ROW_HIT_EN: prefer the oldest entry
// hitting the last popped row, at most MAX_HITS times in a row.
module bank_queue
  import types_def::*;
#(
  parameter int unsigned DEPTH    = BANK_Q_DEPTH,
  parameter int unsigned INDEX_W  = BANK_INDEX_W,
  parameter int unsigned ROW_W    = BANK_ROW_W,
  parameter int unsigned MAX_HITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bank_queue_if.slave            bq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (MAX_HITS == 0)) begin : g_bad_cfg
    $error("bank_queue: DEPTH must be a power of two >= 2 and MAX_HITS >= 1");
  end

  typedef struct packed {
    r_type              req_type;
    logic [INDEX_W-1:0] index;
    logic [ROW_W-1:0]   row;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;

  logic               full, nonempty;
  logic               do_push, do_pop;
  logic [AW-1:0]      sel;
  logic [AW-1:0]      wr_slot;
  entry_t             sel_ent;
  entry_t             push_ent;

  assign full     = (count_q == CW'(DEPTH));
  assign nonempty = (count_q != '0);
  assign do_push  = bq.in_valid && !full;
  assign do_pop   = nonempty && bq.out_ready;
  assign sel_ent  = ent_q[sel];
  assign push_ent = '{req_type: bq.in_type, index: bq.in_index, row: bq.in_row};
  // With a same-cycle pop the free slot has already moved down by one.
  assign wr_slot  = AW'(count_q - CW'(do_pop));

  always_comb begin
    bq.busy      = full;
    bq.out_valid = nonempty;
    bq.out_index = nonempty ? sel_ent.index : '0;
    bq.out_type  = nonempty ? sel_ent.req_type : R_READ;
    bq.out_row   = nonempty ? sel_ent.row : '0;
  end

  assign count        = count_q;
  assign err_overflow = err_q;

  always_comb begin
    ent_d = ent_q;
    if (do_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (AW'(i) >= sel) begin
          ent_d[i] = ent_q[i + 1];
        end
      end
    end
    if (do_push) begin
      ent_d[wr_slot] = push_ent;
    end
  end

  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    err_d   = err_q | (bq.in_valid & full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef BANK_QUEUE_ROW_HIT_EN
  localparam int unsigned SW = $clog2(MAX_HITS + 1);

  logic [ROW_W-1:0]            open_row_q, open_row_d;
  logic                        open_valid_q, open_valid_d;
  logic [SW-1:0]               streak_q, streak_d;
  logic [DEPTH-1:0][ROW_W-1:0] rows;
  logic [DEPTH-1:0]            live;
  logic [AW-1:0]               hit_slot;
  logic                        hit;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rows[i] = ent_q[i].row;
      live[i] = (CW'(i) < count_q);
    end
  end

  bank_queue_select #(
    .DEPTH (DEPTH),
    .ROW_W (ROW_W)
  ) u_select (
    .rows_i       (rows),
    .live_i       (live),
    .open_row_i   (open_row_q),
    .open_valid_i (open_valid_q),
    .slot_o       (hit_slot),
    .hit_o        (hit)
  );

  // Once the streak is exhausted the oldest entry is served regardless.
  always_comb begin
    sel = (hit && (streak_q != SW'(MAX_HITS))) ? hit_slot : '0;
  end

  always_comb begin
    open_row_d   = open_row_q;
    open_valid_d = open_valid_q;
    streak_d     = streak_q;
    if (do_pop) begin
      open_row_d   = sel_ent.row;
      open_valid_d = 1'b1;
      streak_d     = (sel != '0) ? streak_q + SW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_row_q   <= '0;
      open_valid_q <= 1'b0;
      streak_q     <= '0;
    end else begin
      open_row_q   <= open_row_d;
      open_valid_q <= open_valid_d;
      streak_q     <= streak_d;
    end
  end
`else
  always_comb begin
    sel = '0;
  end
`endif

endmodule

// File: tb/tb_bank_queue.sv
// Bench for bank_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model.
module tb_bank_queue;
  import types_def::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned ROW_W    = 16;
  localparam int unsigned MAX_HITS = 4;
  localparam int unsigned CW       = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic          err;

  bank_queue_if #(.INDEX_W(INDEX_W), .ROW_W(ROW_W)) bus ();

  bank_queue #(
    .DEPTH    (DEPTH),
    .INDEX_W  (INDEX_W),
    .ROW_W    (ROW_W),
    .MAX_HITS (MAX_HITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bq           (bus.slave),
    .count        (count),
    .err_overflow (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ty;
    int row;
  } req_t;

  req_t mq[$];
  bit   merr;
`ifdef BANK_QUEUE_ROW_HIT_EN
  int   mopen_row;
  bit   mopen_v;
  int   mstreak;
`endif

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int msel();
`ifdef BANK_QUEUE_ROW_HIT_EN
    if (!mopen_v || mstreak >= MAX_HITS) return 0;
    foreach (mq[i]) begin
      if (mq[i].row == mopen_row) return i;
    end
`endif
    return 0;
  endfunction

  // One clock: drive inputs, check outputs at the falling edge, then advance
  // the model across the rising edge.
  task automatic cycle(input bit iv, input int idx, input int ty, input int row, input bit rdy);
    int   s;
    int   sz;
    bit   pop;
    bit   push;
    req_t r;
    bus.in_valid  = iv;
    bus.in_index  = idx[INDEX_W-1:0];
    bus.in_type   = r_type'(ty[0]);
    bus.in_row    = row[ROW_W-1:0];
    bus.out_ready = rdy;
    @(negedge clk);
    sz = mq.size();
    s  = msel();
    chk("count", count, sz);
    chk("busy", bus.busy, sz == DEPTH);
    chk("out_valid", bus.out_valid, sz > 0);
    chk("err_overflow", err, merr);
    if (sz > 0) begin
      chk("out_index", bus.out_index, mq[s].idx);
      chk("out_type", bus.out_type, mq[s].ty);
      chk("out_row", bus.out_row, mq[s].row);
    end else begin
      chk("out_index_idle", bus.out_index, 0);
      chk("out_row_idle", bus.out_row, 0);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      merr = 1'b0;
`ifdef BANK_QUEUE_ROW_HIT_EN
      mopen_v = 1'b0;
      mstreak = 0;
`endif
    end else begin
      pop  = rdy && (sz > 0);
      push = iv && (sz < DEPTH);
      if (iv && sz == DEPTH) merr = 1'b1;
      if (pop) begin
`ifdef BANK_QUEUE_ROW_HIT_EN
        mopen_row = mq[s].row;
        mopen_v   = 1'b1;
        mstreak   = (s != 0) ? mstreak + 1 : 0;
`endif
        mq.delete(s);
      end
      if (push) begin
        r.idx = idx & ((1 << INDEX_W) - 1);
        r.ty  = ty & 1;
        r.row = row & ((1 << ROW_W) - 1);
        mq.push_back(r);
      end
    end
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_index"}, bus.out_index, 0);
    chk({tag, "_out_type"}, bus.out_type, 0);
    chk({tag, "_out_row"}, bus.out_row, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int rowsel;
    int exp_row[6];
    int exp_idx[6];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_type   = R_READ;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    merr          = 1'b0;
`ifdef BANK_QUEUE_ROW_HIT_EN
    mopen_v   = 1'b0;
    mopen_row = 0;
    mstreak   = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_zero("reset");

    // Fill, overflow, then drain in order.
    for (int i = 1; i <= 8; i++) cycle(1'b1, i, i, 'h100 + i, 1'b0);
    chk("full_busy", bus.busy, 1);
    chk("full_count", count, 8);
    cycle(1'b1, 9, 0, 'h109, 1'b0);
    chk("ovf_err", err, 1);
    chk("ovf_count", count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("fifo_order", bus.out_index, i);
      cycle(1'b0, 0, 0, 0, 1'b1);
    end
    chk("drain_count", count, 0);
    chk("ovf_err_sticky", err, 1);

    // Sustained push+pop at occupancy 3.
    rst = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    for (int i = 11; i <= 13; i++) cycle(1'b1, i, 0, 'h200 + i, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("pp_order", bus.out_index, 11 + k);
      cycle(1'b1, 14 + k, k, 'h200 + 14 + k, 1'b1);
      chk("pp_count", count, 3);
    end
    repeat (3) cycle(1'b0, 0, 0, 0, 1'b1);

    // Push into empty queue while the scheduler is ready.
    chk("empty_count", count, 0);
    cycle(1'b1, 30, 1, 'h330, 1'b1);
    chk("lat1_valid", bus.out_valid, 1);
    chk("lat1_index", bus.out_index, 30);
    cycle(1'b0, 0, 0, 0, 1'b1);
    chk("after_pop_valid", bus.out_valid, 0);
    cycle(1'b0, 0, 0, 0, 1'b1);
    chk("empty_pop_count", count, 0);

    // Reset with entries held.
    for (int i = 0; i < 5; i++) cycle(1'b1, 33 + i, 0, 'h340 + i, 1'b0);
    chk("pre_rst_count", count, 5);
    rst = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    check_idle_zero("mid_reset");
    cycle(1'b1, 40, 1, 'h300, 1'b0);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_index", bus.out_index, 40);
    chk("post_rst_type", bus.out_type, 1);

`ifdef BANK_QUEUE_ROW_HIT_EN
    // Open row 0x10, then rows [0x20, 0x10 x5].
    rst = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 50, 0, 'h10, 1'b0);
    cycle(1'b0, 0, 0, 0, 1'b1);
    cycle(1'b1, 51, 0, 'h20, 1'b0);
    for (int i = 52; i <= 56; i++) cycle(1'b1, i, 0, 'h10, 1'b0);
    exp_row = '{'h10, 'h10, 'h10, 'h10, 'h20, 'h10};
    exp_idx = '{52, 53, 54, 55, 51, 56};
    for (int k = 0; k < 6; k++) begin
      chk("hit_row", bus.out_row, exp_row[k]);
      chk("hit_index", bus.out_index, exp_idx[k]);
      cycle(1'b0, 0, 0, 0, 1'b1);
    end
`else
    exp_row = '{default: 0};
    exp_idx = '{default: 0};
`endif

    // Randomized traffic.
    rst = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rowsel = $urandom_range(0, 3);
      cycle($urandom_range(0, 99) < 60, int'($urandom), int'($urandom),
            (rowsel == 0) ? 'h10 : (rowsel == 1) ? 'h20 : (rowsel == 2) ? 'h30 : int'($urandom),
            $urandom_range(0, 99) < 45);
      if (n == 700) begin
        rst = 1'b1;
        cycle(1'b0, 0, 0, 0, 1'b0);
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bank_queue.md
# bank_queue

Per-bank request queue sitting directly downstream of the address mapper: one instance per bank (16 total), each fed by one bit of the mapper's `bank_out_valid` together with the shared `{index, type, row}` bus. It buffers accepted requests in arrival order, presents the selected entry to the bank scheduler over a valid/ready handshake, and drives the per-bank busy bit back to the mapper so the mapper never pushes into a full queue.

## Interface
- `DEPTH`, 8, queue entries (power of two, ≥ 2)
- `INDEX_W`, 6, global-array index width
- `ROW_W`, 16, row address width
- `MAX_HITS`, 4, maximum consecutive out-of-order pops (row-hit mode only)
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `in_valid`  in  1  push strobe (this bank's bit of the mapper's `bank_out_valid`)
- `in_index`  in  `INDEX_W`  global-array index of pushed request
- `in_type`  in  1  request type of pushed request: `r_type`, read = 0, write = 1
- `in_row`  in  `ROW_W`  row of pushed request
- `busy`  out  1  queue full; mapper must not push
- `out_valid`  out  1  selected entry available
- `out_ready`  in  1  scheduler accepts selected entry
- `out_index`  out  `INDEX_W`  selected entry's index
- `out_type`  out  1  selected entry's type
- `out_row`  out  `ROW_W`  selected entry's row
- `count`  out  log2(`DEPTH`)+1  current occupancy
- `err_overflow`  out  1  sticky: push attempted while full

## Operation
- Storage: compacting array; slot 0 is the oldest entry, valid entries occupy slots 0..`count`-1.
- Push: if `in_valid` && !`busy`, the entry is written to slot `count` after compaction for any same-cycle pop.
- Pop: if `out_valid` && `out_ready`, the selected slot is removed and younger entries shift down by one.
- `busy` = (`count` == `DEPTH`), decoded from the registered count. The mapper samples it combinationally in the same cycle.
- Push while full is dropped and sets `err_overflow`. Only reset clears `err_overflow`.
- Pop while empty: `out_valid` = 0, so no effect.
- Simultaneous push and pop: `count` is unchanged and both take effect.
- Selection without the macro: always slot 0 (strict FIFO).
- `count` never exceeds `DEPTH` and never wraps below 0.

## Timing
- Reset: all outputs are 0 (`busy`, `out_valid`, `out_*`, `count`, `err_overflow`) and the queue is empty. A reset mid-operation discards all entries on the next edge.
- Push at edge N: the entry is visible on `out_*` (if selected) after edge N. There is no same-cycle fall-through, so minimum latency is 1 cycle.
- Pop at edge N: the next selection is visible after edge N, so back-to-back pops are supported every cycle.
- `out_*` is a registered-state decode and is stable while `out_valid` && !`out_ready`.
- `busy` deasserts in the cycle after a pop from full. A push in that same cycle is accepted.

## Configuration
- `BANK_QUEUE_ROW_HIT_EN` defined:
  - Registers `open_row`/`open_valid` are loaded with the row of every popped entry; reset clears `open_valid`.
  - Selection is the lowest slot whose row equals `open_row` (when `open_valid`), else slot 0.
  - `hit_streak` counts consecutive pops taken from a slot other than 0. When it reaches `MAX_HITS`, the next pop is forced from slot 0 and the counter resets to 0.
  - A pop from slot 0 also resets `hit_streak`.
- Undefined: strict FIFO. `open_row` and `hit_streak` logic are absent and `MAX_HITS` is unused.

## Structure
- Shared package `types_def`:
  - add struct `bank_entry` {`r_type req_type`; index; row}
  - add localparams `BANK_Q_DEPTH` and `BANK_COUNT` = 16
  - reuse `r_type` from the package
- One sub-module, `bank_queue_select`: combinational priority search returning the selected slot and a hit flag. It is instantiated only under `BANK_QUEUE_ROW_HIT_EN`.
- A top level instantiates 16 `bank_queue` instances and concatenates their `busy` outputs into the mapper's `in_busy[15:0]`.

## Test plan
- Reset, then push indexes 1..8 with `out_ready` = 0 → `busy` = 1 after the 8th push, `count` = 8. Then pop 8 with `out_ready` = 1 → indexes 1..8 come out in order and `count` = 0.
- With the queue full, push index 9 → entry is dropped, `err_overflow` = 1 and stays 1, `count` stays 8.
- With `count` = 3, push and pop in the same cycle for 10 cycles → `count` stays 3 and output order matches push order.
- Push while empty with `out_ready` = 1 → `out_valid` rises one cycle after the push, then falls after the pop; a pop while empty leaves `count` = 0.
- Assert `rst` with `count` = 5 → next cycle all outputs are 0 and a new push appears after 1 cycle.
- With `BANK_QUEUE_ROW_HIT_EN`, `MAX_HITS` = 4, open row 0x10, queue rows [0x20, 0x10, 0x10, 0x10, 0x10, 0x10] → four 0x10 pops, then the 0x20 entry (forced oldest), then the remaining 0x10.
